// File: rtl/pal_cfg_streamer.sv
//------------------------------------------------------------------------------
// pal_cfg_streamer
//
// Serialises a configuration bitstream into a PAL. Bytes arrive over a
// valid/ready handshake and are shifted out LSB first on cfg_data. Each bit
// gets one cfg_clk period made of CLK_DIV low cycles followed by CLK_DIV high
// cycles; the PAL samples on the rising edge. After CFG_BITS bits the block
// raises cfg_en and pulses done for one cycle.
//
// Parameters
//   CFG_BITS   total configuration bits per load (default 414)
//   CLK_DIV    clk cycles per cfg_clk half-period, >= 1 (default 2)
//
// Ports
//   clk         in   system clock, rising edge
//   res         in   asynchronous active-high reset
//   start       in   one-cycle load request (ignored while busy)
//   abort       in   terminate any load, return to idle
//   word_data   in   next configuration byte, LSB shifted first
//   word_valid  in   word_data holds a valid byte
//   word_ready  out  block accepts a byte this cycle
//   cfg_clk     out  serial configuration clock (registered)
//   cfg_data    out  serial configuration bit (registered)
//   cfg_en      out  configuration-apply enable (registered)
//   busy        out  load in progress
//   done        out  one-cycle completion pulse
//   crc         out  CRC-8 of the shifted bitstream
//
// Build option
//   PAL_CFG_CRC_EN  when defined, crc is a serial CRC-8 (poly 0x07, init 0x00,
//                   no reflection) of the bits in the order they are shifted
//                   out; otherwise crc is tied to 8'h00.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module pal_cfg_streamer #(
    parameter int unsigned CFG_BITS = 414,
    parameter int unsigned CLK_DIV  = 2
) (
    input  logic       clk,
    input  logic       res,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] word_data,
    input  logic       word_valid,
    output logic       word_ready,
    output logic       cfg_clk,
    output logic       cfg_data,
    output logic       cfg_en,
    output logic       busy,
    output logic       done,
    output logic [7:0] crc
);

    localparam int unsigned BW = $clog2(CFG_BITS + 1);
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WORD,
        SHIFT_LO,
        SHIFT_HI,
        APPLY
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]    byte_bits_q, byte_bits_d;
    logic [7:0]    shift_q, shift_d;

    logic          cfg_clk_q, cfg_clk_d;
    logic          cfg_data_q, cfg_data_d;
    logic          cfg_en_q, cfg_en_d;
    logic          word_ready_q, word_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          div_last;

    assign div_last = (div_cnt_q == DW'(CLK_DIV - 1));

    //--------------------------------------------------------------------------
    // Next-state and registered-output logic. All outputs are derived from
    // state_d so that each output register lines up with the state register.
    //--------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        byte_bits_d = byte_bits_q;
        shift_d     = shift_q;
        cfg_en_d    = cfg_en_q;
        cfg_data_d  = cfg_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = WAIT_WORD;
                    bit_cnt_d   = BW'(CFG_BITS);
                    byte_bits_d = '0;
                    cfg_en_d    = 1'b0;
                end
            end

            WAIT_WORD: begin
                // word_ready is high for the whole of this state
                if (word_valid) begin
                    shift_d   = word_data;
                    div_cnt_d = '0;
                    state_d   = SHIFT_LO;
                end
            end

            SHIFT_LO: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    state_d   = SHIFT_HI;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            SHIFT_HI: begin
                if (div_last) begin
                    div_cnt_d   = '0;
                    shift_d     = shift_q >> 1;
                    bit_cnt_d   = bit_cnt_q - 1'b1;
                    byte_bits_d = byte_bits_q + 3'd1;
                    // Last bit of the load ends the stream even mid-byte, so
                    // unused upper bits of a final partial byte are dropped.
                    if (bit_cnt_q == BW'(1)) begin
                        state_d = APPLY;
                    end else if (byte_bits_q == 3'd7) begin
                        state_d = WAIT_WORD;
                    end else begin
                        state_d = SHIFT_LO;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            APPLY: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d    = IDLE;
            cfg_en_d   = 1'b0;
            cfg_data_d = 1'b0;
        end

        if (state_d == APPLY) begin
            cfg_en_d = 1'b1;
        end

        // New bit is presented for the whole low phase and held through high
        if (state_d == SHIFT_LO) begin
            cfg_data_d = shift_d[0];
        end

        cfg_clk_d    = (state_d == SHIFT_HI);
        word_ready_d = (state_d == WAIT_WORD);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == APPLY);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            byte_bits_q  <= '0;
            shift_q      <= '0;
            cfg_clk_q    <= 1'b0;
            cfg_data_q   <= 1'b0;
            cfg_en_q     <= 1'b0;
            word_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            byte_bits_q  <= byte_bits_d;
            shift_q      <= shift_d;
            cfg_clk_q    <= cfg_clk_d;
            cfg_data_q   <= cfg_data_d;
            cfg_en_q     <= cfg_en_d;
            word_ready_q <= word_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign word_ready = word_ready_q;
    assign cfg_clk    = cfg_clk_q;
    assign cfg_data   = cfg_data_q;
    assign cfg_en     = cfg_en_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef PAL_CFG_CRC_EN
    //--------------------------------------------------------------------------
    // Serial CRC-8, updated with the bit being retired as SHIFT_HI ends. The
    // final value lands together with the done pulse and holds until start.
    //--------------------------------------------------------------------------
    logic [7:0] crc_q, crc_d;
    logic       crc_fb;

    assign crc_fb = crc_q[7] ^ shift_q[0];

    always_comb begin
        crc_d = crc_q;
        if (!abort) begin
            if ((state_q == IDLE) && start) begin
                crc_d = '0;
            end else if ((state_q == SHIFT_HI) && div_last) begin
                crc_d = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;
`else
    assign crc = 8'h00;
`endif

endmodule

// File: tb/tb_pal_cfg_streamer.sv
//------------------------------------------------------------------------------
// tb_pal_cfg_streamer
//
// Three instances share clk/res: u_b8 (CFG_BITS=8, CLK_DIV=1), u_b12
// (CFG_BITS=12, CLK_DIV=2) and u_b414 (defaults). Every byte accepted by a DUT
// pushes the bits it should shift into a per-instance queue; a monitor pops
// one bit per cfg_clk rising edge and compares cfg_data.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pal_cfg_streamer;

    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]      start  = '0;
    logic [2:0]      abort  = '0;
    logic [2:0]      wvalid = '0;
    logic [2:0][7:0] wdata  = '0;
    logic [2:0]      wready, cclk, cdata, cen, busy, done;
    logic [2:0][7:0] crc;

    pal_cfg_streamer #(.CFG_BITS(8), .CLK_DIV(1)) u_b8 (
        .clk(clk), .res(res), .start(start[0]), .abort(abort[0]),
        .word_data(wdata[0]), .word_valid(wvalid[0]), .word_ready(wready[0]),
        .cfg_clk(cclk[0]), .cfg_data(cdata[0]), .cfg_en(cen[0]),
        .busy(busy[0]), .done(done[0]), .crc(crc[0]));

    pal_cfg_streamer #(.CFG_BITS(12), .CLK_DIV(2)) u_b12 (
        .clk(clk), .res(res), .start(start[1]), .abort(abort[1]),
        .word_data(wdata[1]), .word_valid(wvalid[1]), .word_ready(wready[1]),
        .cfg_clk(cclk[1]), .cfg_data(cdata[1]), .cfg_en(cen[1]),
        .busy(busy[1]), .done(done[1]), .crc(crc[1]));

    pal_cfg_streamer #(.CFG_BITS(414), .CLK_DIV(2)) u_b414 (
        .clk(clk), .res(res), .start(start[2]), .abort(abort[2]),
        .word_data(wdata[2]), .word_valid(wvalid[2]), .word_ready(wready[2]),
        .cfg_clk(cclk[2]), .cfg_data(cdata[2]), .cfg_en(cen[2]),
        .busy(busy[2]), .done(done[2]), .crc(crc[2]));

    int          checks = 0;
    int          errors = 0;
    int unsigned div_of [3] = '{1, 2, 2};

    logic        exp_q0 [$];
    logic        exp_q1 [$];
    logic        exp_q2 [$];
    logic [7:0]  exp_crc [3] = '{8'h00, 8'h00, 8'h00};

    int unsigned edges [3] = '{0, 0, 0};
    int unsigned dones [3] = '{0, 0, 0};
    int unsigned run   [3] = '{0, 0, 0};
    logic        prev_clk  [3] = '{1'b0, 1'b0, 1'b0};
    logic        prev_done [3] = '{1'b0, 1'b0, 1'b0};
    logic        held      [3] = '{1'b0, 1'b0, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_bit(input int i, input logic b);
        case (i)
            0:       exp_q0.push_back(b);
            1:       exp_q1.push_back(b);
            default: exp_q2.push_back(b);
        endcase
`ifdef PAL_CFG_CRC_EN
        exp_crc[i] = {exp_crc[i][6:0], 1'b0} ^ ((exp_crc[i][7] ^ b) ? 8'h07 : 8'h00);
`endif
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic pop_bit(input int i);
        case (i)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    task automatic clear_q(input int i);
        case (i)
            0:       exp_q0.delete();
            1:       exp_q1.delete();
            default: exp_q2.delete();
        endcase
    endtask

    // Scoreboard consumer: one expected bit per cfg_clk rising edge
    always @(negedge clk) begin
        if (res) begin
            for (int i = 0; i < 3; i++) begin
                prev_clk[i]  = 1'b0;
                prev_done[i] = 1'b0;
                run[i]       = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (cclk[i] && !prev_clk[i]) begin
                    edges[i]++;
                    run[i]  = 1;
                    held[i] = cdata[i];
                    check($sformatf("sb_nonempty_%0d", i), 32'(qsize(i) != 0), 1);
                    if (qsize(i) != 0) begin
                        check($sformatf("cfg_data_%0d_bit%0d", i, edges[i] - 1),
                              32'(cdata[i]), 32'(pop_bit(i)));
                    end
                end else if (cclk[i]) begin
                    run[i]++;
                    check($sformatf("cdata_stable_%0d", i), 32'(cdata[i]), 32'(held[i]));
                end else if (prev_clk[i]) begin
                    check($sformatf("hi_width_%0d", i), run[i], div_of[i]);
                end
                if (done[i]) begin
                    dones[i]++;
                    check($sformatf("done_width_%0d", i), 32'(prev_done[i]), 0);
                    check($sformatf("done_cfg_en_%0d", i), 32'(cen[i]), 1);
                    check($sformatf("done_crc_%0d", i), 32'(crc[i]), 32'(exp_crc[i]));
                end
                prev_clk[i]  = cclk[i];
                prev_done[i] = done[i];
            end
        end
    end

    task automatic begin_load(input int i);
        edges[i]   = 0;
        exp_crc[i] = 8'h00;
        clear_q(i);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic send_byte(input int i, input logic [7:0] b, input int nbits);
        int n = 0;
        wdata[i]  = b;
        wvalid[i] = 1'b1;
        while (!wready[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("ready_seen_%0d", i), 32'(wready[i]), 1);
        for (int k = 0; k < nbits; k++) push_bit(i, b[k]);
        @(negedge clk);
        wvalid[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input string tag);
        int unsigned d0 = dones[i];
        int n = 0;
        while (dones[i] == d0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(tag, dones[i] - d0, 1);
    endtask

    task automatic wait_clk_level(input int i, input logic lvl, input string tag);
        int n = 0;
        while (cclk[i] !== lvl && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(cclk[i]), 32'(lvl));
    endtask

    initial begin
        int unsigned d0;
        int          n;

        // Reset state on every instance
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy_%0d", i),   32'(busy[i]),   0);
            check($sformatf("rst_cclk_%0d", i),   32'(cclk[i]),   0);
            check($sformatf("rst_cdata_%0d", i),  32'(cdata[i]),  0);
            check($sformatf("rst_cen_%0d", i),    32'(cen[i]),    0);
            check($sformatf("rst_wready_%0d", i), 32'(wready[i]), 0);
            check($sformatf("rst_done_%0d", i),   32'(done[i]),   0);
            check($sformatf("rst_crc_%0d", i),    32'(crc[i]),    0);
        end
        res = 1'b0;
        @(negedge clk);

        // 8-bit load of 0xA5, CLK_DIV=1
        begin_load(0);
        check("a5_busy", 32'(busy[0]), 1);
        send_byte(0, 8'hA5, 8);
        wait_done(0, "a5_done");
        @(negedge clk);
        check("a5_edges", edges[0], 8);
        check("a5_sb_empty", 32'(qsize(0)), 0);
        check("a5_cen", 32'(cen[0]), 1);
        check("a5_idle", 32'(busy[0]), 0);

        // 8-bit load of 0x01: checksum at done (monitor), cfg_en cleared by start
        begin_load(0);
        check("x01_cen_clr", 32'(cen[0]), 0);
        check("x01_crc_clr", 32'(crc[0]), 0);
        send_byte(0, 8'h01, 8);
        wait_done(0, "x01_done");
        check("x01_edges", edges[0], 8);

        // 12-bit load with a 20-cycle stall in WAIT_WORD between bytes
        begin_load(1);
        send_byte(1, 8'hFF, 8);
        n = 0;
        while (!wready[1] && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (20) begin
            check("stall_wready", 32'(wready[1]), 1);
            check("stall_cclk", 32'(cclk[1]), 0);
            check("stall_edges", edges[1], 8);
            @(negedge clk);
        end
        send_byte(1, 8'h03, 4);
        wait_done(1, "b12_done");
        repeat (10) @(negedge clk);
        check("b12_edges", edges[1], 12);
        check("b12_sb_empty", 32'(qsize(1)), 0);
        check("b12_cen", 32'(cen[1]), 1);

        // 414-bit load aborted while bit 5 is in its low phase
        begin_load(2);
        send_byte(2, 8'($urandom), 8);
        n = 0;
        while (edges[2] < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ab_reach5", edges[2], 5);
        wait_clk_level(2, 1'b0, "ab_lo_phase");
        d0 = dones[2];
        abort[2] = 1'b1;
        @(negedge clk);
        abort[2] = 1'b0;
        check("ab_busy", 32'(busy[2]), 0);
        check("ab_cclk", 32'(cclk[2]), 0);
        check("ab_cen", 32'(cen[2]), 0);
        check("ab_wready", 32'(wready[2]), 0);
        check("ab_done", 32'(done[2]), 0);
        clear_q(2);
        repeat (30) @(negedge clk);
        check("ab_no_done", dones[2] - d0, 0);
        check("ab_no_edges", edges[2], 5);

        // Fresh full 414-bit load: 51 full bytes plus 6 bits of a last byte
        begin_load(2);
        for (int k = 0; k < 52; k++) send_byte(2, 8'($urandom), (k == 51) ? 6 : 8);
        wait_done(2, "full_done");
        repeat (10) @(negedge clk);
        check("full_edges", edges[2], 414);
        check("full_sb_empty", 32'(qsize(2)), 0);
        check("full_cen", 32'(cen[2]), 1);

        // Asynchronous reset while cfg_clk is high
        begin_load(1);
        send_byte(1, 8'hFF, 8);
        wait_clk_level(1, 1'b1, "rst_hi_phase");
        #2 res = 1'b1;
        #1;
        check("arst_cclk", 32'(cclk[1]), 0);
        check("arst_cdata", 32'(cdata[1]), 0);
        check("arst_cen", 32'(cen[1]), 0);
        check("arst_busy", 32'(busy[1]), 0);
        check("arst_wready", 32'(wready[1]), 0);
        check("arst_done", 32'(done[1]), 0);
        check("arst_crc", 32'(crc[1]), 0);
        @(negedge clk);
        @(negedge clk);
        res = 1'b0;
        clear_q(1);

        // New load from bit 0; a second start mid-load must be ignored
        d0 = dones[1];
        begin_load(1);
        send_byte(1, 8'h5A, 8);
        n = 0;
        while (edges[1] < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        check("ign_busy", 32'(busy[1]), 1);
        send_byte(1, 8'h0C, 4);
        wait_done(1, "ign_done");
        repeat (10) @(negedge clk);
        check("ign_edges", edges[1], 12);
        check("ign_done_cnt", dones[1] - d0, 1);
        check("ign_sb_empty", 32'(qsize(1)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
